// File: rtl/servo_router_pkg.sv
// rtl/servo_router_pkg.sv - shared types, field constants and clamp helper for servo_channel_router
package servo_router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_HI,
        ST_GET_LO,
        ST_DISCARD_HI,
        ST_DISCARD_LO
    } rx_state_e;

    localparam int HDR_FLAG_BIT = 7;
    localparam int CH_FIELD_W   = 6;
    localparam int RAW_W        = 14;

    function automatic logic [RAW_W-1:0] clamp_raw(
        input logic [RAW_W-1:0] raw,
        input int               min_v,
        input int               max_v
    );
        logic [RAW_W-1:0] lo;
        logic [RAW_W-1:0] hi;
        lo = RAW_W'(min_v);
        hi = RAW_W'(max_v);
        if (raw < lo) begin
            return lo;
        end
        if (raw > hi) begin
            return hi;
        end
        return raw;
    endfunction

endpackage

// File: rtl/servo_channel_router_if.sv
// rtl/servo_channel_router_if.sv - byte/period inputs and setpoint outputs; SERVO_ROUTER_WATCHDOG_EN adds wdTimeout
interface servo_channel_router_if #(
    parameter int NUM_CH    = 2,
    parameter int PWM_WIDTH = 7
);
    logic [7:0]                  rxData;
    logic                        rxValid;
    logic                        periodStart;
    logic [NUM_CH*PWM_WIDTH-1:0] pwmSet;
    logic                        updateStrobe;
    logic                        frameErr;
`ifdef SERVO_ROUTER_WATCHDOG_EN
    logic                        wdTimeout;

    modport master (
        output rxData, rxValid, periodStart,
        input  pwmSet, updateStrobe, frameErr, wdTimeout
    );
    modport slave (
        input  rxData, rxValid, periodStart,
        output pwmSet, updateStrobe, frameErr, wdTimeout
    );
`else
    modport master (
        output rxData, rxValid, periodStart,
        input  pwmSet, updateStrobe, frameErr
    );
    modport slave (
        input  rxData, rxValid, periodStart,
        output pwmSet, updateStrobe, frameErr
    );
`endif
endinterface

// File: rtl/servo_shadow_bank.sv
// rtl/servo_shadow_bank.sv - per-channel shadow, pending and committed setpoints with period-boundary commit
module servo_shadow_bank
    import servo_router_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int PWM_WIDTH  = 7,
    parameter int CENTER_VAL = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [CH_FIELD_W-1:0]       wr_ch,
    input  logic [PWM_WIDTH-1:0]        wr_val,
    input  logic                        fail_safe,
    input  logic                        commit,
    output logic [NUM_CH*PWM_WIDTH-1:0] pwm_set,
    output logic                        update_strobe
);
    localparam logic [PWM_WIDTH-1:0] CENTER = PWM_WIDTH'(CENTER_VAL);

    logic [PWM_WIDTH-1:0]        shadow_q [NUM_CH];
    logic [PWM_WIDTH-1:0]        shadow_d [NUM_CH];
    logic [NUM_CH-1:0]           pending_q, pending_d;
    logic [NUM_CH*PWM_WIDTH-1:0] committed_q, committed_d;
    logic                        update_q, update_d;

    // A write landing on a commit edge goes straight through: it was already eligible this period.
    always_comb begin
        pending_d   = pending_q;
        committed_d = committed_q;
        update_d    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            shadow_d[k] = shadow_q[k];
            if (commit) begin
                if (wr_en && (wr_ch == CH_FIELD_W'(k))) begin
                    shadow_d[k]                            = wr_val;
                    committed_d[k*PWM_WIDTH +: PWM_WIDTH]  = wr_val;
                    pending_d[k]                           = 1'b0;
                    update_d                               = 1'b1;
                end else if (pending_q[k]) begin
                    committed_d[k*PWM_WIDTH +: PWM_WIDTH]  = shadow_q[k];
                    pending_d[k]                           = 1'b0;
                    update_d                               = 1'b1;
                end
            end else if (wr_en && (wr_ch == CH_FIELD_W'(k))) begin
                shadow_d[k]  = wr_val;
                pending_d[k] = 1'b1;
            end
            if (fail_safe) begin
                shadow_d[k]  = CENTER;
                pending_d[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= CENTER;
            end
            pending_q   <= '0;
            committed_q <= {NUM_CH{CENTER}};
            update_q    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                shadow_q[k] <= shadow_d[k];
            end
            pending_q   <= pending_d;
            committed_q <= committed_d;
            update_q    <= update_d;
        end
    end

    assign pwm_set       = committed_q;
    assign update_strobe = update_q;

endmodule

// File: rtl/servo_channel_router.sv
// rtl/servo_channel_router.sv - UART frame decoder feeding shadowed servo setpoints; optional SERVO_ROUTER_WATCHDOG_EN
module servo_channel_router
    import servo_router_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int PWM_WIDTH      = 7,
    parameter int MIN_VAL        = 0,
    parameter int MAX_VAL        = 127,
    parameter int CENTER_VAL     = 64,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input logic                    clk,
    input logic                    reset,
    servo_channel_router_if.slave  bus
);
    localparam int                  CH_LIM_W = CH_FIELD_W + 1;
    localparam logic [CH_LIM_W-1:0] CH_LIM   = CH_LIM_W'(NUM_CH);

    rx_state_e               state_q, state_d;
    logic [CH_FIELD_W-1:0]   ch_q, ch_d;
    logic [6:0]              hi_q, hi_d;
    logic                    done_q, done_d;
    logic [CH_FIELD_W-1:0]   done_ch_q, done_ch_d;
    logic [PWM_WIDTH-1:0]    done_val_q, done_val_d;
    logic                    frame_err_q, frame_err_d;
    logic                    is_hdr, ch_ok;
    logic                    fail_safe;

    assign is_hdr = bus.rxData[HDR_FLAG_BIT];
    assign ch_ok  = {1'b0, bus.rxData[CH_FIELD_W-1:0]} < CH_LIM;

    // A header always restarts parsing; it is an error only if it cuts a frame short.
    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        hi_d        = hi_q;
        done_d      = 1'b0;
        done_ch_d   = done_ch_q;
        done_val_d  = done_val_q;
        frame_err_d = 1'b0;
        if (bus.rxValid) begin
            if (is_hdr) begin
                if (state_q != ST_IDLE) begin
                    frame_err_d = 1'b1;
                end
                if (ch_ok) begin
                    ch_d    = bus.rxData[CH_FIELD_W-1:0];
                    state_d = ST_GET_HI;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = ST_DISCARD_HI;
                end
            end else begin
                case (state_q)
                    ST_IDLE:       frame_err_d = 1'b1;
                    ST_GET_HI: begin
                        hi_d    = bus.rxData[6:0];
                        state_d = ST_GET_LO;
                    end
                    ST_GET_LO: begin
                        done_d     = 1'b1;
                        done_ch_d  = ch_q;
                        done_val_d = PWM_WIDTH'(clamp_raw({hi_q, bus.rxData[6:0]}, MIN_VAL, MAX_VAL));
                        state_d    = ST_IDLE;
                    end
                    ST_DISCARD_HI: state_d = ST_DISCARD_LO;
                    ST_DISCARD_LO: state_d = ST_IDLE;
                    default:       state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            hi_q        <= '0;
            done_q      <= 1'b0;
            done_ch_q   <= '0;
            done_val_q  <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            hi_q        <= hi_d;
            done_q      <= done_d;
            done_ch_q   <= done_ch_d;
            done_val_q  <= done_val_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef SERVO_ROUTER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_fire_q, wd_fire_d;
    logic            wd_timeout_q, wd_timeout_d;

    always_comb begin
        wd_fire_d    = 1'b0;
        wd_timeout_d = wd_timeout_q;
        if (done_d) begin
            wd_cnt_d     = '0;
            wd_timeout_d = 1'b0;
        end else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            wd_cnt_d     = '0;
            wd_fire_d    = 1'b1;
            wd_timeout_d = 1'b1;
        end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q     <= '0;
            wd_fire_q    <= 1'b0;
            wd_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            wd_fire_q    <= wd_fire_d;
            wd_timeout_q <= wd_timeout_d;
        end
    end

    assign fail_safe     = wd_fire_q;
    assign bus.wdTimeout = wd_timeout_q;
`else
    assign fail_safe = 1'b0;
`endif

    servo_shadow_bank #(
        .NUM_CH     (NUM_CH),
        .PWM_WIDTH  (PWM_WIDTH),
        .CENTER_VAL (CENTER_VAL)
    ) u_bank (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (done_q),
        .wr_ch         (done_ch_q),
        .wr_val        (done_val_q),
        .fail_safe     (fail_safe),
        .commit        (bus.periodStart),
        .pwm_set       (bus.pwmSet),
        .update_strobe (bus.updateStrobe)
    );

    assign bus.frameErr = frame_err_q;

endmodule

// File: tb/tb_servo_channel_router.sv
// tb/tb_servo_channel_router.sv - directed frames checked every cycle against a queue-based frame/commit model
module tb_servo_channel_router;
    localparam int NCH = 2;
    localparam int PW  = 7;
    localparam int MINV = 0;
    localparam int MAXV = 127;
    localparam int CTR  = 64;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   run = 0;
    int   upd_cnt = 0;
    int   err_cnt = 0;

    servo_channel_router_if #(.NUM_CH(NCH), .PWM_WIDTH(PW)) bus ();

    servo_channel_router #(
        .NUM_CH(NCH), .PWM_WIDTH(PW), .MIN_VAL(MINV), .MAX_VAL(MAXV), .CENTER_VAL(CTR)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: in-flight frame tracking plus a log of writes stamped with the first edge they may commit on.
    int   cyc_n;
    int   cur_ch;
    bit   disc;
    int   dn;
    int   nbytes;
    int   hi_b;
    int   wq_ch[$];
    int   wq_val[$];
    int   wq_el[$];
    int   m_pwm[NCH];
    bit   exp_upd;
    bit   exp_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int raw);
        if (raw < MINV) return MINV;
        if (raw > MAXV) return MAXV;
        return raw;
    endfunction

    task automatic model_reset();
        cyc_n = 0; cur_ch = -1; disc = 0; dn = 0; nbytes = 0; hi_b = 0;
        wq_ch.delete(); wq_val.delete(); wq_el.delete();
        for (int i = 0; i < NCH; i++) m_pwm[i] = CTR;
        exp_upd = 0; exp_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] d, input bit ps);
        bit upd;
        bit err;
        int kch[$];
        int kval[$];
        int kel[$];
        upd = 0; err = 0;
        cyc_n++;
        if (ps) begin
            for (int i = 0; i < wq_ch.size(); i++) begin
                if (wq_el[i] <= cyc_n) begin
                    m_pwm[wq_ch[i]] = wq_val[i];
                    upd = 1;
                end else begin
                    kch.push_back(wq_ch[i]); kval.push_back(wq_val[i]); kel.push_back(wq_el[i]);
                end
            end
            wq_ch = kch; wq_val = kval; wq_el = kel;
        end
        if (v) begin
            if (d[7]) begin
                if (cur_ch >= 0 || disc) err = 1;
                disc = 0; cur_ch = -1; nbytes = 0;
                if (int'(d[5:0]) < NCH) cur_ch = int'(d[5:0]);
                else begin err = 1; disc = 1; dn = 0; end
            end else if (disc) begin
                dn++;
                if (dn == 2) disc = 0;
            end else if (cur_ch < 0) begin
                err = 1;
            end else if (nbytes == 0) begin
                hi_b = int'(d[6:0]); nbytes = 1;
            end else begin
                wq_ch.push_back(cur_ch);
                wq_val.push_back(clampv(hi_b * 128 + int'(d[6:0])));
                wq_el.push_back(cyc_n + 1);
                cur_ch = -1; nbytes = 0;
            end
        end
        exp_upd = upd;
        exp_err = err;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("pwmSet", 32'(bus.pwmSet), 32'({7'(m_pwm[1]), 7'(m_pwm[0])}));
            chk("updateStrobe", 32'(bus.updateStrobe), 32'(exp_upd));
            chk("frameErr", 32'(bus.frameErr), 32'(exp_err));
            if (bus.updateStrobe) upd_cnt++;
            if (bus.frameErr) err_cnt++;
        end
    end

    task automatic step(input bit v, input logic [7:0] d, input bit ps);
        bus.rxValid = v; bus.rxData = d; bus.periodStart = ps;
        @(posedge clk);
        model_step(v, d, ps);
        #1;
        bus.rxValid = 0; bus.rxData = 8'h00; bus.periodStart = 0;
    endtask

    task automatic byte_in(input logic [7:0] d);
        step(1'b1, d, 1'b0);
    endtask

    task automatic commit_period();
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int e0;
    int u0;

    initial begin
        bus.rxValid = 0; bus.rxData = 8'h00; bus.periodStart = 0;
        reset = 1'b1;
        model_reset();
        run = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        settle();
        chk("reset_pwm", 32'(bus.pwmSet), 32'h2040);

        u0 = upd_cnt;
        byte_in(8'h80); byte_in(8'h00); byte_in(8'h50);
        commit_period();
        settle();
        chk("t1_ch0", 32'(bus.pwmSet[6:0]), 80);
        chk("t1_ch1", 32'(bus.pwmSet[13:7]), 64);
        chk("t1_strobes", 32'(upd_cnt - u0), 1);

        byte_in(8'h81); byte_in(8'h01); byte_in(8'h00);
        commit_period();
        settle();
        chk("t2_clamp", 32'(bus.pwmSet[13:7]), 127);

        e0 = err_cnt;
        byte_in(8'h85); byte_in(8'h10); byte_in(8'h20);
        byte_in(8'h80); byte_in(8'h00); byte_in(8'h10);
        commit_period();
        settle();
        chk("t3_errs", 32'(err_cnt - e0), 1);
        chk("t3_ch0", 32'(bus.pwmSet[6:0]), 16);

        e0 = err_cnt;
        byte_in(8'h80); byte_in(8'h05);
        byte_in(8'h81); byte_in(8'h00); byte_in(8'h22);
        commit_period();
        settle();
        chk("t4_errs", 32'(err_cnt - e0), 1);
        chk("t4_ch0", 32'(bus.pwmSet[6:0]), 16);
        chk("t4_ch1", 32'(bus.pwmSet[13:7]), 34);

        byte_in(8'h80); byte_in(8'h00);
        step(1'b1, 8'h33, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        settle();
        chk("t5_held", 32'(bus.pwmSet[6:0]), 16);
        commit_period();
        settle();
        chk("t5_next", 32'(bus.pwmSet[6:0]), 51);

        byte_in(8'h80); byte_in(8'h00); byte_in(8'h20);
        step(1'b0, 8'h00, 1'b1);
        settle();
        chk("lat_n1", 32'(bus.pwmSet[6:0]), 32);

        byte_in(8'h80); byte_in(8'h00); byte_in(8'h0A);
        byte_in(8'h80); byte_in(8'h00); byte_in(8'h0B);
        byte_in(8'h81); byte_in(8'h7F); byte_in(8'h7F);
        commit_period();
        settle();
        chk("last_wins", 32'(bus.pwmSet[6:0]), 11);
        chk("max_raw", 32'(bus.pwmSet[13:7]), 127);

        e0 = err_cnt;
        byte_in(8'h80); byte_in(8'hC1); byte_in(8'h00); byte_in(8'h05);
        commit_period();
        settle();
        chk("hdr_restart_err", 32'(err_cnt - e0), 1);
        chk("hdr_restart_ch1", 32'(bus.pwmSet[13:7]), 5);

        byte_in(8'h81); byte_in(8'h00);
        do_reset();
        settle();
        chk("t6_reset_pwm", 32'(bus.pwmSet), 32'h2040);
        e0 = err_cnt;
        byte_in(8'h11);
        commit_period();
        settle();
        chk("t6_lone_lo_err", 32'(err_cnt - e0), 1);
        chk("t6_pwm", 32'(bus.pwmSet), 32'h2040);

        run = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/servo_channel_router.md
Name: servo_channel_router

Overview:
Parametrised successor to the two-axis servo select logic. It decodes UART byte frames into per-channel PWM setpoints for NUM_CH servos at PWM_WIDTH resolution. New values are held in shadow registers and committed only on the PWM period boundary, so a servo never sees a mid-period change. It sits between the UART receiver and the PWM generator bank.

Parameters:
NUM_CH, 2, number of servo channels (1..64)
PWM_WIDTH, 7, setpoint width in bits (1..14)
MIN_VAL, 0, lower clamp for a setpoint
MAX_VAL, 127, upper clamp for a setpoint (must be <= 2^PWM_WIDTH-1)
CENTER_VAL, 64, reset value and watchdog fallback value for every channel
TIMEOUT_CYCLES, 50000000, watchdog timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic is on the rising edge
reset  in  1  asynchronous, active-high reset
rxData  in  8  received UART byte
rxValid  in  1  single-cycle strobe, synchronous to clk; rxData is valid in that cycle
periodStart  in  1  single-cycle pulse from the PWM bank at the start of each PWM period
pwmSet  out  NUM_CH*PWM_WIDTH  committed setpoints; channel k occupies bits [k*PWM_WIDTH +: PWM_WIDTH]
updateStrobe  out  1  one-cycle pulse when at least one channel is committed
frameErr  out  1  one-cycle pulse on a protocol error

Behaviour:
- Frame format: header byte (bit7=1, bits[5:0]=channel, bit6 reserved and ignored), then data byte HI (bit7=0, payload [6:0]), then data byte LO (bit7=0, payload [6:0]). The raw value is {HI[6:0], LO[6:0]}, 14 bits.
- Reset: pwmSet = CENTER_VAL on all channels; shadow registers = CENTER_VAL; pending flags cleared; FSM in IDLE; updateStrobe = 0; frameErr = 0.
- FSM states: IDLE, GET_HI, GET_LO, DISCARD_HI, DISCARD_LO. Transitions occur only on cycles with rxValid=1.
- IDLE: a header with a valid channel (< NUM_CH) latches the channel and moves to GET_HI. A header with channel >= NUM_CH pulses frameErr and moves to DISCARD_HI. A data byte pulses frameErr and stays in IDLE.
- GET_HI: a data byte latches HI and moves to GET_LO.
- GET_LO: a data byte completes the frame and returns to IDLE.
- DISCARD_HI/DISCARD_LO: data bytes are consumed silently; the FSM then returns to IDLE.
- Header in any non-IDLE state: the partial frame is dropped, frameErr pulses, and the new header is processed as if the FSM were in IDLE (same cycle).
- Frame completion: the raw value is clamped to [MIN_VAL, MAX_VAL] and truncated to PWM_WIDTH. The result is written to the channel's shadow register one clock after the LO byte. The channel's pending flag is set. A later frame to the same channel before commit overwrites the shadow value (last write wins).
- Commit: on a cycle with periodStart=1, every pending channel copies shadow to pwmSet on that edge, and pending flags clear. updateStrobe pulses in the following cycle if any channel was pending. Non-pending channels hold their value.
- Simultaneous events: if frame completion and periodStart fall in the same cycle, periodStart commits only the previously pending values. The new value stays pending for the next periodStart.
- Latency: LO byte accepted in cycle N gives a shadow update at edge N+1. Commit happens at the first periodStart sampled at or after cycle N+1.
- Reset asserted mid-frame: all state returns to reset values immediately, and the partial frame is lost.

Optional Feature:
Macro SERVO_ROUTER_WATCHDOG_EN.
- With the macro: a counter increments every clk cycle and clears on every completed valid frame. On reaching TIMEOUT_CYCLES, all shadow registers load CENTER_VAL and all pending flags set, so outputs fail safe at the next periodStart. A sticky output port wdTimeout (1 bit) goes high and clears on the next completed frame or on reset.
- Without the macro: there is no counter, no wdTimeout port, and setpoints hold indefinitely.

Decomposition:
- Package servo_router_pkg contains:
  - the FSM state encoding
  - HDR_FLAG_BIT=7
  - CH_FIELD_W=6
  - RAW_W=14
  - the clamp function
- One natural sub-module: servo_shadow_bank, which holds the per-channel shadow, pending and committed registers plus the commit logic. The FSM stays in the top level.

Test Plan:
- Reset, then frame 0x80,0x00,0x50 to ch0 followed by periodStart → pwmSet ch0 = 80 (0x50); ch1 stays 64; updateStrobe pulses once.
- Frame 0x81,0x01,0x00 (raw 128), MAX_VAL=127 → ch1 committed value = 127 (clamped).
- Frame 0x85 (invalid ch, NUM_CH=2),0x10,0x20 then 0x80,0x00,0x10 → one frameErr pulse; the two data bytes are ignored; ch0 = 16 after periodStart.
- Bytes 0x80,0x05, then 0x81,0x00,0x22 → frameErr pulse on 0x81; ch0 unchanged; ch1 = 34 after periodStart.
- LO byte accepted in the same cycle as periodStart → no commit that period; value appears at the next periodStart.
- Reset asserted between HI and LO bytes → outputs = 64; the following LO byte alone produces a frameErr pulse.
